// File: rtl/router_pkg.sv
// Shared types for the router output scheduler.
// Holds the FSM state encoding, header field positions, the egress buffer
// entry layout and the round-robin pick helper.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int LEN_MSB   = 7;
  localparam int LEN_LSB   = 2;

  typedef enum logic [1:0] {IDLE, HDR, HWAIT, BODY} state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
  } buf_entry_t;

  // First requesting port after 'last' in circular order; returns 'last'
  // when nothing requests. The loop runs downwards so the nearest
  // candidate is the final (winning) assignment.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [NUM_PORTS-1:0] req);
    logic [1:0] pick;
    logic [1:0] cand;
    pick = last;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = 2'((int'(last) + i) % NUM_PORTS);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/router_sched_buf.sv
// Purpose: small sync FIFO of egress entries between FIFO capture and the link.
// Latency: push visible at the head the cycle after the push edge.
// Backpressure: pop only on pop_vld & pop_rdy; the writer must never push when full.
// Ports: clk/rst, push_vld/push_dat (write side), pop_rdy/pop_vld/head_dat
//        (read side), count (occupancy 0..DEPTH).
module router_sched_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_vld,
  input  buf_entry_t                   push_dat,
  input  logic                         pop_rdy,
  output logic                         pop_vld,
  output buf_entry_t                   head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  buf_entry_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop_vld  = (count != '0);
  assign do_pop   = pop_vld && pop_rdy;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)   rd_ptr <= ptr_inc(rd_ptr);
      case ({push_vld, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_out_sched.sv
// Purpose: round-robin picks one of three output FIFOs and serializes whole packets onto one link.
// Latency: FIFO read at t is captured at the t+2 edge; link byte is valid the cycle after capture.
// Backpressure: link_ready low fills the egress buffer; FIFO reads stop once buffered+in-flight hits BUF_DEPTH.
// Ports: vld_out_k/data_out_k/soft_reset_k from FIFO k, read_en_k pops FIFO k;
//        link_* egress byte with valid/ready; abort pulses when a granted packet
//        is abandoned; busy while a packet is still being fetched.
module router_out_sched
  import router_pkg::*;
#(
  parameter int BUF_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_out_0,
  input  logic       vld_out_1,
  input  logic       vld_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       link_ready,
  output logic       read_en_0,
  output logic       read_en_1,
  output logic       read_en_2,
  output logic [7:0] link_data,
  output logic       link_valid,
  output logic       link_sop,
  output logic       link_eop,
  output logic [1:0] link_port,
  output logic       abort,
  output logic       busy
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t     state, state_nxt;
  // grant doubles as the round-robin pointer: it always holds the last port served.
  logic [1:0] grant, grant_nxt;
  logic [6:0] left, left_nxt;
  logic       pend;      // a FIFO read issued last cycle; its data is on data_out now
  logic       pend_eop;  // that read was the final byte of the packet
  logic       issue;
  logic       abort_now;
  logic       cap;
  logic       room;
  logic       vld_sel;
  logic       srst_sel;
  logic [7:0] data_sel;
  buf_entry_t cap_entry;
  buf_entry_t head;
  logic       head_vld;
  logic [CW-1:0] buf_count;

  always_comb begin
    vld_sel  = 1'b0;
    srst_sel = 1'b0;
    data_sel = '0;
    case (grant)
      2'd0:    begin vld_sel = vld_out_0; srst_sel = soft_reset_0; data_sel = data_out_0; end
      2'd1:    begin vld_sel = vld_out_1; srst_sel = soft_reset_1; data_sel = data_out_1; end
      default: begin vld_sel = vld_out_2; srst_sel = soft_reset_2; data_sel = data_out_2; end
    endcase
  end

  // In-flight reads count against buffer space so a capture always fits.
  assign room      = (int'(buf_count) + int'(pend)) < BUF_DEPTH;
  assign abort_now = ((state == HWAIT) || (state == BODY)) && srst_sel;
  assign issue     = !abort_now && vld_sel && room &&
                     ((state == HDR) || ((state == BODY) && (left != 7'd0)));
  assign cap       = pend && !abort_now;

  assign read_en_0 = issue && (grant == 2'd0);
  assign read_en_1 = issue && (grant == 2'd1);
  assign read_en_2 = issue && (grant == 2'd2);

  assign cap_entry = '{data: data_sel, sop: (state == HWAIT), eop: pend_eop, port: grant};

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    left_nxt  = left;
    case (state)
      IDLE: begin
        if (vld_out_0 || vld_out_1 || vld_out_2) begin
          grant_nxt = rr_pick(grant, {vld_out_2, vld_out_1, vld_out_0});
          state_nxt = HDR;
        end
      end
      HDR: begin
        if (issue) state_nxt = HWAIT;
      end
      HWAIT: begin
        if (abort_now) begin
          state_nxt = IDLE;
        end else if (pend) begin
          // Payload bytes plus the trailing parity byte.
          left_nxt  = 7'(data_sel[LEN_MSB:LEN_LSB]) + 7'd1;
          state_nxt = BODY;
        end
      end
      BODY: begin
        if (abort_now) begin
          state_nxt = IDLE;
        end else begin
          if (issue) left_nxt = left - 7'd1;
          if ((left == 7'd0) && !pend) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 2'd2;
      left     <= '0;
      pend     <= 1'b0;
      pend_eop <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      left     <= left_nxt;
      pend     <= issue;
      pend_eop <= issue && (state == BODY) && (left == 7'd1);
    end
  end

  router_sched_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push_vld (cap),
    .push_dat (cap_entry),
    .pop_rdy  (link_ready),
    .pop_vld  (head_vld),
    .head_dat (head),
    .count    (buf_count)
  );

  // Gate the head fields so an empty link shows zeros rather than stale entries.
  assign link_valid = head_vld;
  assign link_data  = head_vld ? head.data : '0;
  assign link_sop   = head_vld && head.sop;
  assign link_eop   = head_vld && head.eop;
  assign link_port  = head_vld ? head.port : '0;
  assign abort      = abort_now;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_router_out_sched.sv
// Bench for router_out_sched: models the three FIFOs, predicts the link byte
// stream from the packet queues with a round-robin over whole packets, and
// compares every accepted link byte plus read/abort/reset behaviour.
module tb_router_out_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld_out_0, vld_out_1, vld_out_2;
  logic [7:0] data_out_0, data_out_1, data_out_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       link_ready;
  logic       read_en_0, read_en_1, read_en_2;
  logic [7:0] link_data;
  logic       link_valid, link_sop, link_eop;
  logic [1:0] link_port;
  logic       abort, busy;

  always #5 clk = ~clk;

  router_out_sched #(.BUF_DEPTH(3)) dut (
    .clk(clk), .rst(rst),
    .vld_out_0(vld_out_0), .vld_out_1(vld_out_1), .vld_out_2(vld_out_2),
    .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .link_ready(link_ready),
    .read_en_0(read_en_0), .read_en_1(read_en_1), .read_en_2(read_en_2),
    .link_data(link_data), .link_valid(link_valid), .link_sop(link_sop),
    .link_eop(link_eop), .link_port(link_port), .abort(abort), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fq [3][$];   // FIFO contents still to be popped
  int          rem [3];     // bytes left of the packet currently being popped
  logic [11:0] exp_q [$];   // {data, sop, eop, port} in expected link order
  int          rd_cnt [3];
  int          n_acc, n_abort, cyc, first_rd, first_acc;
  int          rdy_pct, stall_pct, rr_last;
  bit          inv_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int total_rd();
    return rd_cnt[0] + rd_cnt[1] + rd_cnt[2];
  endfunction

  task automatic add_pkt(input int p, input int len);
    logic [7:0] h, b, par;
    h = {6'(len), 2'(p)};
    fq[p].push_back(h);
    par = h;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      fq[p].push_back(b);
      par ^= b;
    end
    fq[p].push_back(par);
  endtask

  // Expected stream: whole packets, next port chosen circularly after the last served.
  task automatic build_exp();
    int idx [3];
    int p, q, n;
    bit more;
    logic [7:0] hb;
    idx = '{0, 0, 0};
    more = 1'b1;
    while (more) begin
      more = 1'b0;
      p = 0;
      for (int i = 3; i >= 1; i--) begin
        q = (rr_last + i) % 3;
        if (idx[q] < fq[q].size()) begin p = q; more = 1'b1; end
      end
      if (more) begin
        hb = fq[p][idx[p]];
        n  = int'(hb[7:2]) + 2;
        for (int j = 0; j < n; j++)
          exp_q.push_back({fq[p][idx[p]+j], 1'(j == 0), 1'(j == n - 1), 2'(p)});
        idx[p] += n;
        rr_last = p;
      end
    end
  endtask

  task automatic drive_inputs();
    logic [2:0] v;
    for (int k = 0; k < 3; k++)
      v[k] = (fq[k].size() != 0) && !((rem[k] != 0) && ($urandom_range(0, 99) < stall_pct));
    vld_out_0  = v[0];
    vld_out_1  = v[1];
    vld_out_2  = v[2];
    link_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic cycle();
    logic [2:0] re, vv;
    logic [7:0] b;
    @(negedge clk);
    cyc++;
    re = {read_en_2, read_en_1, read_en_0};
    vv = {vld_out_2, vld_out_1, vld_out_0};
    if (re != 3'b000) begin
      chk("read_en_onehot", $countones(re), 1);
      if (first_rd < 0) first_rd = cyc;
    end
    for (int k = 0; k < 3; k++)
      if (re[k]) begin
        chk("read_en_needs_vld", vv[k], 1);
        rd_cnt[k]++;
      end
    if (inv_en) chk("outstanding_le_depth", 32'((total_rd() - n_acc) <= 3), 1);
    if (abort) n_abort++;
    if (link_valid && link_ready) begin
      if (first_acc < 0) first_acc = cyc;
      n_acc++;
      if (exp_q.size() == 0) chk("link_extra_byte", 32'(exp_q.size()), 1);
      else chk("link_byte", {link_data, link_sop, link_eop, link_port}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      if (re[k] && fq[k].size() != 0) begin
        b = fq[k].pop_front();
        if (rem[k] == 0) rem[k] = int'(b[7:2]) + 1;
        else rem[k]--;
        case (k)
          0:       data_out_0 = b;
          1:       data_out_1 = b;
          default: data_out_2 = b;
        endcase
      end
    drive_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      fq[k].delete();
      rem[k] = 0;
      rd_cnt[k] = 0;
    end
    vld_out_0 = 0; vld_out_1 = 0; vld_out_2 = 0;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    link_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_acc = 0; n_abort = 0; first_rd = -1; first_acc = -1;
    rr_last = 2; rdy_pct = 100; stall_pct = 0; inv_en = 1'b1;
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while (b < budget && !(exp_q.size() == 0 && !busy && !link_valid &&
           fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0)) begin
      cycle();
      b++;
    end
    chk("drain_done", 32'(b < budget), 1);
  endtask

  function automatic logic [17:0] out_vec();
    return {read_en_0, read_en_1, read_en_2, link_valid, link_sop, link_eop,
            abort, busy, link_port, link_data};
  endfunction

  initial begin
    int tot, r2;
    rst = 1'b1;
    vld_out_0 = 0; vld_out_1 = 0; vld_out_2 = 0;
    data_out_0 = 0; data_out_1 = 0; data_out_2 = 0;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
    link_ready = 0;
    #1;
    chk("reset_outputs", 32'(out_vec()), 0);

    // Single port-1 packet, header 0x11 (len 4).
    do_reset();
    add_pkt(1, 4);
    chk("hdr_value", 32'(fq[1][0]), 32'h11);
    build_exp();
    drive_inputs();
    drain(200);
    chk("p1_read_count", rd_cnt[1], 6);
    chk("p1_link_count", n_acc, 6);
    chk("p1_first_latency", first_acc - first_rd, 2);

    // All ports requesting, len 2 each, port 0 twice: order 0,1,2,0.
    do_reset();
    add_pkt(0, 2); add_pkt(1, 2); add_pkt(2, 2); add_pkt(0, 2);
    build_exp();
    drive_inputs();
    drain(300);
    chk("rr_link_count", n_acc, 16);

    // link_ready low six cycles mid-body.
    do_reset();
    add_pkt(0, 12);
    build_exp();
    drive_inputs();
    r2 = 0;
    while (n_acc < 3 && r2 < 100) begin cycle(); r2++; end
    chk("stall_reached_body", 32'(n_acc >= 3), 1);
    rdy_pct = 0;
    link_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (i == 2) r2 = rd_cnt[0];
    end
    chk("stall_no_late_reads", rd_cnt[0] - r2, 0);
    chk("stall_buffer_full", total_rd() - n_acc, 3);
    rdy_pct = 100;
    drive_inputs();
    drain(300);
    chk("stall_read_count", rd_cnt[0], 14);

    // Zero-length packet on port 2.
    do_reset();
    add_pkt(2, 0);
    chk("len0_hdr_value", 32'(fq[2][0]), 32'h02);
    build_exp();
    drive_inputs();
    drain(100);
    chk("len0_link_count", n_acc, 2);

    // Soft reset of the granted port mid-body.
    do_reset();
    inv_en = 1'b0;
    add_pkt(2, 10);
    for (int j = 0; j < 3; j++) exp_q.push_back({fq[2][j], 1'(j == 0), 1'b0, 2'd2});
    drive_inputs();
    r2 = 0;
    while (rd_cnt[2] < 4 && r2 < 100) begin cycle(); r2++; end
    chk("abort_reached_body", rd_cnt[2], 4);
    soft_reset_2 = 1'b1;
    cycle();
    chk("abort_pulse", n_abort, 1);
    chk("abort_blocks_read", rd_cnt[2], 4);
    soft_reset_2 = 1'b0;
    fq[2].delete();
    rem[2] = 0;
    add_pkt(0, 1);
    build_exp();
    drive_inputs();
    drain(200);
    chk("abort_once", n_abort, 1);
    chk("abort_no_more_p2", rd_cnt[2], 4);
    chk("abort_next_p0", rd_cnt[0], 3);
    chk("abort_link_count", n_acc, 6);

    // Asynchronous reset mid-packet, then port 0 must win first.
    do_reset();
    add_pkt(1, 20);
    build_exp();
    drive_inputs();
    repeat (6) cycle();
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 32'(out_vec()), 0);
    do_reset();
    add_pkt(2, 1); add_pkt(1, 1); add_pkt(0, 1);
    build_exp();
    drive_inputs();
    drain(200);
    chk("rst_after_link_count", n_acc, 9);

    // Randomized packet mixes with random backpressure and FIFO gaps.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      tot = 0;
      for (int p = 0; p < 3; p++) begin
        int np;
        np = $urandom_range(0, 3);
        for (int k = 0; k < np; k++) begin
          int len;
          len = $urandom_range(0, 12);
          add_pkt(p, len);
          tot += len + 2;
        end
      end
      rdy_pct   = $urandom_range(30, 100);
      stall_pct = $urandom_range(0, 40);
      build_exp();
      drive_inputs();
      drain(3000);
      chk("rand_read_total", total_rd(), tot);
      chk("rand_link_total", n_acc, tot);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
